// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS CPU: data width, reset vector,
// the bubble instruction and the instruction-fetch state encoding.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register with a one-entry hold buffer. A word fetched while
// decode is stalled is parked here and released once the stall clears.
module ifid_reg
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_fetch,
  input  logic [XLEN-1:0] fetch_inst,
  input  logic [XLEN-1:0] fetch_pc4,
  input  logic            park,
  input  logic            load_hold,
  input  logic            bubble,
  input  logic            clear_hold,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc4,
  output logic            dvalid
);

  logic [XLEN-1:0] hinst;
  logic [XLEN-1:0] hpc4;

  // Hold buffer: captures a fetched word that decode cannot take yet
  always_ff @(posedge clock) begin
    if (reset || clear_hold) begin
      hinst <= NOP_WORD;
      hpc4  <= '0;
    end else if (park) begin
      hinst <= fetch_inst;
      hpc4  <= fetch_pc4;
    end
  end

  // IF/ID register: new fetch, released hold word, bubble, or hold as-is
  always_ff @(posedge clock) begin
    if (reset) begin
      inst   <= NOP_WORD;
      dpc4   <= '0;
      dvalid <= 1'b0;
    end else if (load_fetch) begin
      inst   <= fetch_inst;
      dpc4   <= fetch_pc4;
      dvalid <= 1'b1;
    end else if (load_hold) begin
      inst   <= hinst;
      dpc4   <= hpc4;
      dvalid <= 1'b1;
    end else if (bubble) begin
      inst   <= NOP_WORD;
      dvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the REQ/HOLD fetch FSM and the
// branch/jump redirect handling, and feeds the IF/ID register.
// Build option DELAY_SLOT_EN: keep the MIPS branch delay slot instead of
// squashing the word after a taken branch/jump.
module if_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc4,
  output logic            dvalid
);

  fetch_state_t    state;
  logic            accept;
  logic            redirect_q;
  logic            load_fetch;
  logic            park;
  logic            load_hold;
  logic            bubble;
  logic            clear_hold;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4   = pc + XLEN'(4);
  assign accept     = (state == REQ) && imem_rdy;
  assign redirect_q = redirect && !stall;
  assign imem_req   = (state == REQ) && !reset;
  assign imem_addr  = pc;
  assign park       = accept && stall;

`ifdef DELAY_SLOT_EN
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;

  assign load_fetch = accept && !stall;
  assign load_hold  = (state == HOLD) && !stall;
  assign bubble     = !stall && (state == REQ) && !imem_rdy;
  assign clear_hold = 1'b0;

  // PC, fetch FSM and deferred redirect target while the delay slot is fetched
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= REQ;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      assert (!(redirect_q && pend_valid));
      if (redirect_q && (accept || state == HOLD)) begin
        pc <= redirect_pc;
      end else if (redirect_q) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end else if (accept) begin
        pc         <= pend_valid ? pend_pc : pc_plus4;
        pend_valid <= 1'b0;
      end
      if (accept && stall) begin
        state <= HOLD;
      end else if (state == HOLD && !stall) begin
        state <= REQ;
      end
    end
  end
`else
  assign load_fetch = accept && !stall && !redirect_q;
  assign load_hold  = (state == HOLD) && !stall && !redirect_q;
  assign bubble     = !stall && (redirect_q || ((state == REQ) && !imem_rdy));
  assign clear_hold = redirect_q;

  // PC and fetch FSM; a redirect squashes whatever is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= REQ;
    end else begin
      if (redirect_q) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc <= pc_plus4;
      end
      if (redirect_q) begin
        state <= REQ;
      end else if (accept && stall) begin
        state <= HOLD;
      end else if (state == HOLD && !stall) begin
        state <= REQ;
      end
    end
  end
`endif

  ifid_reg #(
    .NOP_WORD(NOP_INST)
  ) u_ifid (
    .clock     (clock),
    .reset     (reset),
    .load_fetch(load_fetch),
    .fetch_inst(imem_rdata),
    .fetch_pc4 (pc_plus4),
    .park      (park),
    .load_hold (load_hold),
    .bubble    (bubble),
    .clear_hold(clear_hold),
    .inst      (inst),
    .dpc4      (dpc4),
    .dvalid    (dvalid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage (default build): directed scenarios followed by
// random traffic, all compared against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] dpc4;
  logic        dvalid;

  int errors;
  int checks;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_dpc4;
  logic        m_valid;
  logic [63:0] parked[$];

  if_fetch_stage dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .dpc4       (dpc4),
    .dvalid     (dvalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h0000_0000;
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234} | 32'h1;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: one clock of fetch behaviour from the stage's externally visible rules
  task automatic modelStep(input logic rst, input logic st, input logic rd,
                           input logic [31:0] rpc, input logic rdy);
    logic        fetching;
    logic        got;
    logic [31:0] word;
    logic [63:0] held;
    fetching = (parked.size() == 0);
    got      = fetching && rdy;
    word     = mem_word(m_pc);
    if (rst) begin
      m_pc    = 32'h0;
      m_inst  = 32'h0;
      m_dpc4  = 32'h0;
      m_valid = 1'b0;
      parked.delete();
    end else if (rd && !st) begin
      m_pc    = rpc;
      m_inst  = 32'h0;
      m_valid = 1'b0;
      parked.delete();
    end else if (st) begin
      if (got) begin
        parked.push_back({word, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end else if (got) begin
      m_inst  = word;
      m_dpc4  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end else if (!fetching) begin
      held    = parked.pop_front();
      m_inst  = held[63:32];
      m_dpc4  = held[31:0];
      m_valid = 1'b1;
    end else begin
      m_inst  = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checkValue("pc", pc, m_pc);
    checkValue("imem_addr", imem_addr, m_pc);
    checkValue("inst", inst, m_inst);
    checkValue("dpc4", dpc4, m_dpc4);
    checkValue("dvalid", {31'b0, dvalid}, {31'b0, m_valid});
    checkValue("imem_req", {31'b0, imem_req},
               {31'b0, (!reset && parked.size() == 0)});
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic rdy);
    reset       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdy    = rdy;
    #1;
    if (rst) checkValue("req_in_reset", {31'b0, imem_req}, 32'h0);
    modelStep(rst, st, rd, rpc, rdy);
    @(posedge clock);
    #1;
    checkOutput();
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] r;
    logic        r_rst, r_st, r_rd, r_rdy;
    errors = 0;
    checks = 0;
    m_pc = 0; m_inst = 0; m_dpc4 = 0; m_valid = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_rdy = 1'b0;
    @(negedge clock);

    // Reset, then zero-wait fetch from 0x0
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("first_inst", inst, 32'h2001_0005);
    checkValue("first_dpc4", dpc4, 32'h4);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("second_dpc4", dpc4, 32'h8);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("pc_at_0x10", pc, 32'h10);

    // imem wait states at 0x10
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("wait_addr", imem_addr, 32'h10);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("after_wait_dpc4", dpc4, 32'h14);

    // Accept under stall, hold for two cycles, then release
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("held_release_dpc4", dpc4, 32'h18);
    applyStimulus(0, 0, 0, 0, 1);

    // Redirect coinciding with the accept of 0x24 squashes it
    applyStimulus(0, 0, 1, 32'h24, 1);
    applyStimulus(0, 0, 1, 32'h100, 1);
    checkValue("squash_addr", imem_addr, 32'h100);
    checkValue("squash_valid", {31'b0, dvalid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("target_dpc4", dpc4, 32'h104);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkValue("wrap_pc", pc, 32'h0);
    checkValue("wrap_dpc4", dpc4, 32'h0);

    // Reset while in HOLD drops the parked word
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkValue("hold_reset_valid", {31'b0, dvalid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);

    // Redirect during stall is ignored
    applyStimulus(0, 1, 1, 32'h200, 0);
    checkValue("stalled_redirect_pc", pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r = $urandom();
      r[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
      applyStimulus(r_rst, r_st, r_rd, r, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
